popcount_frame_stats: RTL

//  Downstream consumer of the bit population counter. Takes per-word popcounts and groups them into frames of

---
 rtl/popcount_pkg.sv | 14 +
 rtl/popcount_stats_slot.sv | 35 +++
 rtl/popcount_frame_stats.sv | 102 ++++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared widths, accumulator state type for the frame statistics block
package popcount_pkg;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int sum_width(input int width, input int frame_len);
    return $clog2(width * frame_len + 1);
  endfunction

  typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_t;

endpackage

// File: rtl/popcount_stats_slot.sv
// rtl/popcount_stats_slot.sv - one-entry valid/ready result register with reject/drop indication
module popcount_stats_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          reject,
  output logic          drop
);

  // A held result is only replaced when it is consumed in the same cycle.
  assign reject = load && valid && !ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      drop  <= 1'b0;
    end else begin
      drop <= reject;
      if (load && (!valid || ready)) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/popcount_frame_stats.sv
// rtl/popcount_frame_stats.sv - groups per-word popcounts into frames and reports sum/max/min/words
module popcount_frame_stats
  import popcount_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int FRAME_LEN = 16,
  parameter  int DROP_W    = 16,
  localparam int CNT_W     = cnt_width(WIDTH),
  localparam int WCNT_W    = $clog2(FRAME_LEN) + 1,
  localparam int SUM_W     = sum_width(WIDTH, FRAME_LEN)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              cnt_val_i,
  input  logic              flush_i,
  output logic [SUM_W-1:0]  sum_o,
  output logic [CNT_W-1:0]  max_o,
  output logic [CNT_W-1:0]  min_o,
  output logic [WCNT_W-1:0] words_o,
  output logic              stats_val_o,
  input  logic              stats_ready_i,
  output logic              drop_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  typedef struct packed {
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  max;
    logic [CNT_W-1:0]  min;
    logic [WCNT_W-1:0] words;
  } stats_t;

  acc_state_t        state, state_n;
  stats_t            cur, cur_n, acc, frame, held;
  logic [CNT_W-1:0]  cnt_c;
  logic              close, reject;
  logic [DROP_W-1:0] drop_cnt;

  assign cnt_c = (cnt_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cnt_i;

  always_comb begin
    acc     = cur;
    frame   = cur;
    close   = 1'b0;
    state_n = state;
    cur_n   = cur;
    if (state == ACC_IDLE) begin
      acc.sum   = SUM_W'(cnt_c);
      acc.max   = cnt_c;
      acc.min   = cnt_c;
      acc.words = WCNT_W'(1);
    end else begin
      acc.sum   = cur.sum + SUM_W'(cnt_c);
      acc.max   = (cnt_c > cur.max) ? cnt_c : cur.max;
      acc.min   = (cnt_c < cur.min) ? cnt_c : cur.min;
      acc.words = cur.words + WCNT_W'(1);
    end
    if (cnt_val_i) frame = acc;
    // A flush with a word in IDLE closes a one-word frame; a lone flush in IDLE is ignored.
    close = (cnt_val_i && cur.words == WCNT_W'(FRAME_LEN - 1)) ||
            (flush_i && (state == ACC_RUN || cnt_val_i));
    if (close) begin
      state_n = ACC_IDLE;
      cur_n   = '0;
    end else if (cnt_val_i) begin
      state_n = ACC_RUN;
      cur_n   = acc;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state    <= ACC_IDLE;
      cur      <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      if (reject && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  popcount_stats_slot #(.DW($bits(stats_t))) u_slot (
    .clk       (clk_i),
    .rst_n     (arst_n_i),
    .load      (close),
    .load_data (frame),
    .ready     (stats_ready_i),
    .valid     (stats_val_o),
    .data      (held),
    .reject    (reject),
    .drop      (drop_o)
  );

  assign sum_o      = held.sum;
  assign max_o      = held.max;
  assign min_o      = held.min;
  assign words_o    = held.words;
  assign drop_cnt_o = drop_cnt;

endmodule
